// File: rtl/vmem_port_arbiter.sv
// Arbitrates scalar accesses and strided vector bursts onto RAM port A, one access per cycle.
// Optional VMEM_SCALAR_PREEMPT_EN: scalar requests pre-empt an active burst for one cycle each.
module vmem_port_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_req,
  input  logic                  s_we,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_gnt,
  output logic                  s_rvalid,
  input  logic                  v_req,
  input  logic                  v_we,
  input  logic [ADDR_WIDTH-1:0] v_base,
  input  logic [ADDR_WIDTH-1:0] v_stride,
  input  logic [LEN_W-1:0]      v_len,
  input  logic [DATA_WIDTH-1:0] v_wdata,
  output logic                  v_ack,
  output logic                  v_issue,
  output logic [LEN_W-1:0]      v_idx,
  output logic                  v_rvalid,
  output logic                  v_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_w,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic                  last_vec_q, last_vec_d;
  logic [LEN_W-1:0]      idx_q, idx_d, len_q, len_d;
  logic [ADDR_WIDTH-1:0] nxt_q, nxt_d, stride_q, stride_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [DATA_WIDTH-1:0] last_din_q, rdata_q;
  logic                  s_rvalid_q, v_rvalid_q, done_q;

  logic                  gnt_s, ack_v, issue_v, access, acc_we, done_d;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_din;
  logic [LEN_W-1:0]      idx_out;

  always_comb begin
    state_d    = state_q;
    last_vec_d = last_vec_q;
    idx_d      = idx_q;
    len_d      = len_q;
    nxt_d      = nxt_q;
    stride_d   = stride_q;
    we_d       = we_q;
    gnt_s      = 1'b0;
    ack_v      = 1'b0;
    issue_v    = 1'b0;
    access     = 1'b0;
    acc_we     = 1'b0;
    acc_addr   = last_addr_q;
    acc_din    = last_din_q;
    idx_out    = '0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Tie goes to whichever requester did not win last time.
        if (s_req && (!v_req || last_vec_q)) begin
          gnt_s      = 1'b1;
          last_vec_d = 1'b0;
          access     = 1'b1;
          acc_we     = s_we;
          acc_addr   = s_addr;
          acc_din    = s_wdata;
        end else if (v_req) begin
          ack_v      = 1'b1;
          last_vec_d = 1'b1;
          len_d      = v_len;
          stride_d   = v_stride;
          we_d       = v_we;
          if (v_len == '0) begin
            done_d = 1'b1;
          end else begin
            issue_v  = 1'b1;
            access   = 1'b1;
            acc_we   = v_we;
            acc_addr = v_base;
            acc_din  = v_wdata;
            nxt_d    = v_base + v_stride;
            idx_d    = LEN_W'(1);
            if (v_len == LEN_W'(1)) done_d = 1'b1;
            else                    state_d = BURST;
          end
        end
      end
      BURST: begin
        idx_out = idx_q;
`ifdef VMEM_SCALAR_PREEMPT_EN
        if (s_req) begin
          gnt_s      = 1'b1;
          last_vec_d = 1'b0;
          access     = 1'b1;
          acc_we     = s_we;
          acc_addr   = s_addr;
          acc_din    = s_wdata;
        end else
`endif
        begin
          issue_v  = 1'b1;
          access   = 1'b1;
          acc_we   = we_q;
          acc_addr = nxt_q;
          acc_din  = v_wdata;
          nxt_d    = nxt_q + stride_q;
          idx_d    = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_vec_q  <= 1'b1;
      idx_q       <= '0;
      len_q       <= '0;
      nxt_q       <= '0;
      stride_q    <= '0;
      we_q        <= 1'b0;
      last_addr_q <= '0;
      last_din_q  <= '0;
      rdata_q     <= '0;
      s_rvalid_q  <= 1'b0;
      v_rvalid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_vec_q  <= last_vec_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      nxt_q       <= nxt_d;
      stride_q    <= stride_d;
      we_q        <= we_d;
      last_addr_q <= acc_addr;
      last_din_q  <= acc_din;
      s_rvalid_q  <= gnt_s & ~acc_we;
      v_rvalid_q  <= issue_v & ~acc_we;
      done_q      <= done_d;
      if (access && !acc_we) rdata_q <= ram_dout_a;
    end
  end

  // Combinational outputs are masked so reset forces them low within the same cycle.
  assign s_gnt      = gnt_s & ~rst;
  assign v_ack      = ack_v & ~rst;
  assign v_issue    = issue_v & ~rst;
  assign v_idx      = rst ? '0 : idx_out;
  assign ram_w      = access & acc_we & ~rst;
  assign ram_addr_a = rst ? '0 : acc_addr;
  assign ram_din_a  = rst ? '0 : acc_din;
  assign s_rvalid   = s_rvalid_q;
  assign v_rvalid   = v_rvalid_q;
  assign v_done     = done_q;
  assign rdata      = rdata_q;

endmodule
